// File: rtl/bmp_pkg.sv
// bmp_pkg: shared constants, mode encodings and FSM state type for the bitmap assembler.
package bmp_pkg;
   localparam int BMP_ROWS = 64;
   localparam int BMP_COLS = 24;
   localparam int BMP_BITS = BMP_ROWS * BMP_COLS;
   localparam logic MODE_ROW = 1'b0;
   localparam logic MODE_COL = 1'b1;
   typedef enum logic [1:0] {IDLE, FILL, DONE} bmp_state_e;
endpackage

// File: rtl/bmp_assembler_if.sv
// bmp_assembler_if: slice input handshake and completed-bitmap handshake between producer/consumer and assembler.
interface bmp_assembler_if #(parameter int ROWS = 64, parameter int COLS = 24, parameter int IDXW = 6);
   logic                 start;
   logic                 mode;
   logic                 row_dir;
   logic                 slice_valid;
   logic [ROWS-1:0]      slice_in;
   logic                 slice_ready;
   logic [IDXW-1:0]      slice_idx;
   logic                 bmp_valid;
   logic [ROWS*COLS-1:0] bmpout;
   logic                 bmp_ack;
   logic                 busy;
   modport master (output start, mode, row_dir, slice_valid, slice_in, bmp_ack,
                   input slice_ready, slice_idx, bmp_valid, bmpout, busy);
   modport slave  (input start, mode, row_dir, slice_valid, slice_in, bmp_ack,
                   output slice_ready, slice_idx, bmp_valid, bmpout, busy);
endinterface

// File: rtl/bmp_slice_writer.sv
// bmp_slice_writer: maps one row or column slice at a given index to a full-bitmap write mask and data.
module bmp_slice_writer
   import bmp_pkg::*;
#(
   parameter int ROWS = BMP_ROWS,
   parameter int COLS = BMP_COLS,
   parameter int IDXW = 6
) (
   input  logic                 mode_i,
   input  logic [IDXW-1:0]      idx_i,
   input  logic [ROWS-1:0]      slice_in_i,
   output logic [ROWS*COLS-1:0] mask_o,
   output logic [ROWS*COLS-1:0] data_o
);
   for (genvar r = 0; r < ROWS; r++) begin : g_row
      for (genvar c = 0; c < COLS; c++) begin : g_col
         // column slices are MSB-first: slice bit ROWS-1 belongs to row 0
         assign mask_o[r*COLS+c] = (mode_i == MODE_ROW) ? (idx_i == IDXW'(r)) : (idx_i == IDXW'(c));
         assign data_o[r*COLS+c] = (mode_i == MODE_ROW) ? slice_in_i[c] : slice_in_i[ROWS-1-r];
      end
   end
endmodule

// File: rtl/bmp_assembler.sv
// bmp_assembler: reassembles 24-bit row or 64-bit column slices into a 24x64 bitmap.
// Define BMP_ASSEMBLER_CLEAR_EN to zero the buffer on every start; otherwise new passes overlay old data.
module bmp_assembler
   import bmp_pkg::*;
#(
   parameter int ROWS = BMP_ROWS,
   parameter int COLS = BMP_COLS,
   parameter int IDXW = 6
) (
   input logic             clk,
   input logic             rst_n,
   bmp_assembler_if.slave  bus
);
   bmp_state_e           state_q, state_d;
   logic [IDXW-1:0]      idx_q, idx_d;
   logic [IDXW:0]        cnt_q, cnt_d;
   logic                 mode_q, mode_d;
   logic                 desc_q, desc_d;
   logic [ROWS*COLS-1:0] buf_q, buf_d;
   logic [ROWS*COLS-1:0] wr_mask, wr_data;
   logic                 xfer, last, start_desc;

   bmp_slice_writer #(.ROWS(ROWS), .COLS(COLS), .IDXW(IDXW)) u_writer (
      .mode_i     (mode_q),
      .idx_i      (idx_q),
      .slice_in_i (bus.slice_in),
      .mask_o     (wr_mask),
      .data_o     (wr_data)
   );

   assign xfer       = bus.slice_valid && state_q == FILL && !bus.start;
   assign last       = cnt_q == (mode_q == MODE_COL ? (IDXW+1)'(COLS-1) : (IDXW+1)'(ROWS-1));
   assign start_desc = bus.mode == MODE_ROW && bus.row_dir;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      desc_d  = desc_q;
      buf_d   = buf_q;
      if (bus.start) begin
         state_d = FILL;
         mode_d  = bus.mode;
         desc_d  = start_desc;
         idx_d   = start_desc ? IDXW'(ROWS-1) : '0;
         cnt_d   = '0;
`ifdef BMP_ASSEMBLER_CLEAR_EN
         buf_d   = '0;
`endif
      end else if (xfer) begin
         buf_d   = (buf_q & ~wr_mask) | (wr_data & wr_mask);
         cnt_d   = cnt_q + 1'b1;
         // index holds on the final slice so it never leaves the valid range
         idx_d   = last ? idx_q : desc_q ? idx_q - 1'b1 : idx_q + 1'b1;
         state_d = last ? DONE : FILL;
      end else if (state_q == DONE && bus.bmp_ack) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         mode_q  <= MODE_ROW;
         desc_q  <= 1'b0;
         buf_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         desc_q  <= desc_d;
         buf_q   <= buf_d;
      end
   end

   assign bus.slice_ready = state_q == FILL;
   assign bus.busy        = state_q == FILL;
   assign bus.bmp_valid   = state_q == DONE;
   assign bus.slice_idx   = idx_q;
   assign bus.bmpout      = buf_q;
endmodule

// File: doc/bmp_assembler.md
Name: bmp_assembler

Overview:
- Inverse of the bitmap slicer: collects 24-bit row slices or 64-bit column slices returned by the ALU and reassembles them into a full 24x64 bitmap (1536 bits) for the CPU.
- Sits between the ALU result path and the CPU bitmap write-back.
- Uses a valid/ready slice handshake and a valid/ack handshake on the completed bitmap.

Parameters:
- ROWS, 64, number of rows; row slice count.
- COLS, 24, number of columns; column slice count and row width.
- IDXW, 6, width of slice index counter; must satisfy 2**IDXW >= max(ROWS, COLS).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a new assembly and latches mode and row_dir.
- mode  in  1  0 = row slices, 1 = column slices; sampled on start.
- row_dir  in  1  row mode only: 0 = ascending from row 0, 1 = descending from row ROWS-1; sampled on start.
- slice_valid  in  1  slice_in holds a slice.
- slice_in  in  ROWS  slice data; row mode uses bits [COLS-1:0], upper bits ignored.
- slice_ready  out  1  block accepts a slice this cycle.
- slice_idx  out  IDXW  index the next accepted slice is written to.
- bmp_valid  out  1  bmpout holds a complete bitmap.
- bmpout  out  ROWS*COLS  assembled bitmap.
- bmp_ack  in  1  consumer has taken bmpout.
- busy  out  1  high in FILL.

Behaviour:
- Layout:
  - Row r occupies bmpout[r*COLS+COLS-1 : r*COLS].
  - Column c, row r is bit c + COLS*r.
  - In a column slice, slice_in[ROWS-1] is row 0 and slice_in[0] is row ROWS-1 (MSB = row 0).
- FSM states are IDLE, FILL and DONE.
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - Buffer, slice_idx, bmp_valid, slice_ready and busy all go to 0.
  - Reset mid-FILL or mid-DONE discards all progress.
- IDLE:
  - slice_ready=0; slice_valid is ignored.
  - start → FILL next cycle.
  - slice_idx loads 0, or ROWS-1 when mode=0 and row_dir=1.
  - Slice count loads 0.
- FILL:
  - slice_ready=1 and busy=1.
  - A transfer occurs when slice_valid && slice_ready at a clock edge.
  - On a transfer, the slice is written at slice_idx and the count increments.
  - slice_idx moves +1 (ascending or column mode) or -1 (descending).
  - The transfer that completes the last slice (count reaches ROWS in row mode, COLS in column mode) moves the FSM to DONE.
  - bmp_valid=1 on the cycle after the last transfer, so latency from last slice to bmp_valid is 1 cycle.
- DONE:
  - bmp_valid=1, slice_ready=0; bmpout is stable.
  - bmp_ack → IDLE, with bmp_valid=0 the next cycle; bmpout keeps its contents.
- start in FILL or DONE:
  - Aborts and restarts immediately: counters reload, state goes to FILL, bmp_valid drops next cycle.
  - start has priority over a same-cycle transfer (that slice is dropped) and over a same-cycle bmp_ack.
- bmp_ack outside DONE is ignored.
- Index wrap never occurs: the transition to DONE happens before slice_idx can leave the range [0, ROWS-1] or [0, COLS-1].
- The buffer retains old contents between assemblies (see optional feature).

Optional Feature:
- Macro: BMP_ASSEMBLER_CLEAR_EN.
- Defined: start also zeroes the entire buffer in the same edge that enters FILL, so unwritten bits always read 0.
- Undefined: the buffer is untouched by start. A new assembly overlays the previous bitmap, which allows row then column composition via two passes.

Decomposition:
- Shared package bmp_pkg holds:
  - constants BMP_ROWS=64, BMP_COLS=24, BMP_BITS=1536;
  - mode encodings MODE_ROW=1'b0 and MODE_COL=1'b1;
  - FSM state typedef {IDLE, FILL, DONE}.
- One natural sub-module, bmp_slice_writer: combinational write-mask/data generator from (mode, slice_idx, slice_in) to a 1536-bit mask and data. The top keeps the FSM, counters and buffer register.

Test Plan:
- Row ascending: start(mode=0, row_dir=0), 64 slices with slice_in=idx → bmpout[r*24+23:r*24]==r for all r; bmp_valid rises exactly 1 cycle after the 64th transfer.
- Row descending: start(mode=0, row_dir=1), first slice 24'hABCDEF → lands at bmpout[1535:1512]; slice_idx sequence 63→0; DONE after 64 transfers.
- Column mode: 24 slices, slice c = 64'h8000_0000_0000_0001 → bits c (row 0) and c+1512 (row 63) set, all others 0 (CLEAR_EN defined); bmp_valid after 24th transfer.
- Backpressure/handshake: toggle slice_valid randomly → only valid&&ready cycles advance slice_idx; slice_valid in DONE is ignored; bmp_ack returns to IDLE and bmpout holds its value.
- Abort: start again after 10 row slices → slice_idx reloads 0 and 64 more slices are required; start coincident with slice_valid drops that slice.
- Reset: rst_n low mid-FILL (asynchronous, between edges) → outputs 0 immediately, state IDLE; without CLEAR_EN, a second column pass preserves prior row data in unwritten bits.
